sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port among NREQ requesters.
// Optional macro SDRAM_ARB_PORT0_PRIORITY_EN: port 0 always wins when pending.
//
// state  | meaning
// S_IDLE | no transaction downstream; issue to the next pending port if any
// S_WAIT | one transaction outstanding; wait for in_sd_done and route it back
module sdram_port_arbiter #(
    parameter int NREQ = 2,
    parameter int GW   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ*32-1:0] in_req_addr,
    input  logic [NREQ-1:0]    in_req_rw,
    input  logic [NREQ*32-1:0] in_req_data_in,
    input  logic [NREQ*4-1:0]  in_req_wmask,
    input  logic [NREQ-1:0]    in_req_in_valid,
    output logic [NREQ-1:0]    out_req_done,
    output logic [31:0]        out_req_data_out,
    output logic [31:0]        out_sd_addr,
    output logic               out_sd_rw,
    output logic [31:0]        out_sd_data_in,
    output logic [3:0]         out_sd_wmask,
    output logic               out_sd_in_valid,
    input  logic [31:0]        in_sd_data_out,
    input  logic               in_sd_done,
    output logic [GW-1:0]      out_grant,
    output logic               out_busy,
    output logic               out_overrun
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t            state_q;
    logic [NREQ-1:0]   pending_q, pending_d;
    logic [GW-1:0]     ptr_q;
    logic [GW-1:0]     grant_q;
    logic [31:0]       lat_addr_q [NREQ];
    logic [NREQ-1:0]   lat_rw_q;
    logic [31:0]       lat_data_q [NREQ];
    logic [3:0]        lat_wmask_q [NREQ];

    logic [NREQ-1:0]   req_done_q;
    logic [31:0]       req_data_q;
    logic [31:0]       sd_addr_q;
    logic              sd_rw_q;
    logic [31:0]       sd_data_q;
    logic [3:0]        sd_wmask_q;
    logic              sd_valid_q;
    logic              busy_q;
    logic              overrun_q, overrun_d;

    logic [NREQ-1:0]   accept;
    logic [NREQ-1:0]   search_mask;
    logic              sel_found_d;
    logic [GW-1:0]     sel_idx_d;
    logic [31:0]       sel_addr_d;
    logic              sel_rw_d;
    logic [31:0]       sel_data_d;
    logic [3:0]        sel_wmask_d;
    logic              wait_done;
    logic [GW-1:0]     ptr_after_done;

    assign wait_done = (state_q == S_WAIT) && in_sd_done;

    // A port that is pending (including the one being served) cannot accept a new pulse.
    always_comb begin
        accept    = in_req_in_valid & ~pending_q;
        overrun_d = overrun_q | (|(in_req_in_valid & pending_q));
        pending_d = pending_q;
        if (wait_done) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_q == GW'(i)) begin
                    pending_d[i] = 1'b0;
                end
            end
        end
        pending_d = pending_d | accept;
    end

    always_comb begin
        int idx;
        sel_found_d = 1'b0;
        sel_idx_d   = '0;
        search_mask = pending_q;
        idx         = 0;
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
        if (pending_q[0]) begin
            sel_found_d = 1'b1;
        end
        search_mask[0] = 1'b0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!sel_found_d && search_mask[idx]) begin
                sel_found_d = 1'b1;
                sel_idx_d   = GW'(idx);
            end
        end
    end

    always_comb begin
        sel_addr_d  = '0;
        sel_rw_d    = 1'b1;
        sel_data_d  = '0;
        sel_wmask_d = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx_d == GW'(i)) begin
                sel_addr_d  = lat_addr_q[i];
                sel_rw_d    = lat_rw_q[i];
                sel_data_d  = lat_data_q[i];
                sel_wmask_d = lat_wmask_q[i];
            end
        end
    end

    always_comb begin
        if (grant_q == GW'(NREQ - 1)) begin
            ptr_after_done = '0;
        end else begin
            ptr_after_done = grant_q + GW'(1);
        end
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
        // Serving port 0 is out-of-band and leaves the rotation where it was.
        if (grant_q == '0) begin
            ptr_after_done = ptr_q;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            lat_rw_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                lat_addr_q[i]  <= '0;
                lat_data_q[i]  <= '0;
                lat_wmask_q[i] <= '0;
            end
            req_done_q <= '0;
            req_data_q <= '0;
            sd_addr_q  <= '0;
            sd_rw_q    <= 1'b1;
            sd_data_q  <= '0;
            sd_wmask_q <= 4'hF;
            sd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            req_done_q <= '0;
            sd_valid_q <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    lat_addr_q[i]  <= in_req_addr[32*i +: 32];
                    lat_rw_q[i]    <= in_req_rw[i];
                    lat_data_q[i]  <= in_req_data_in[32*i +: 32];
                    lat_wmask_q[i] <= in_req_wmask[4*i +: 4];
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (sel_found_d) begin
                        grant_q    <= sel_idx_d;
                        sd_addr_q  <= sel_addr_d;
                        sd_rw_q    <= sel_rw_d;
                        sd_data_q  <= sel_data_d;
                        sd_wmask_q <= sel_wmask_d;
                        sd_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (in_sd_done) begin
                        for (int i = 0; i < NREQ; i++) begin
                            if (grant_q == GW'(i)) begin
                                req_done_q[i] <= 1'b1;
                            end
                        end
                        req_data_q <= in_sd_data_out;
                        busy_q     <= 1'b0;
                        ptr_q      <= ptr_after_done;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_req_done     = req_done_q;
    assign out_req_data_out = req_data_q;
    assign out_sd_addr      = sd_addr_q;
    assign out_sd_rw        = sd_rw_q;
    assign out_sd_data_in   = sd_data_q;
    assign out_sd_wmask     = sd_wmask_q;
    assign out_sd_in_valid  = sd_valid_q;
    assign out_grant        = grant_q;
    assign out_busy         = busy_q;
    assign out_overrun      = overrun_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (NREQ=2); expectations follow the macro setting.
module tb_sdram_port_arbiter;

    localparam int NREQ = 2;
    localparam int GW   = 2;

    logic               clock;
    logic               reset;
    logic [NREQ*32-1:0] in_req_addr;
    logic [NREQ-1:0]    in_req_rw;
    logic [NREQ*32-1:0] in_req_data_in;
    logic [NREQ*4-1:0]  in_req_wmask;
    logic [NREQ-1:0]    in_req_in_valid;
    logic [NREQ-1:0]    out_req_done;
    logic [31:0]        out_req_data_out;
    logic [31:0]        out_sd_addr;
    logic               out_sd_rw;
    logic [31:0]        out_sd_data_in;
    logic [3:0]         out_sd_wmask;
    logic               out_sd_in_valid;
    logic [31:0]        in_sd_data_out;
    logic               in_sd_done;
    logic [GW-1:0]      out_grant;
    logic               out_busy;
    logic               out_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    sdram_port_arbiter #(.NREQ(NREQ), .GW(GW)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_req_addr      (in_req_addr),
        .in_req_rw        (in_req_rw),
        .in_req_data_in   (in_req_data_in),
        .in_req_wmask     (in_req_wmask),
        .in_req_in_valid  (in_req_in_valid),
        .out_req_done     (out_req_done),
        .out_req_data_out (out_req_data_out),
        .out_sd_addr      (out_sd_addr),
        .out_sd_rw        (out_sd_rw),
        .out_sd_data_in   (out_sd_data_in),
        .out_sd_wmask     (out_sd_wmask),
        .out_sd_in_valid  (out_sd_in_valid),
        .in_sd_data_out   (in_sd_data_out),
        .in_sd_done       (in_sd_done),
        .out_grant        (out_grant),
        .out_busy         (out_busy),
        .out_overrun      (out_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int p, input logic [31:0] addr, input logic rw,
                           input logic [31:0] data, input logic [3:0] mask);
        in_req_addr[32*p +: 32]    = addr;
        in_req_rw[p]               = rw;
        in_req_data_in[32*p +: 32] = data;
        in_req_wmask[4*p +: 4]     = mask;
        in_req_in_valid[p]         = 1'b1;
    endtask

    task automatic sd_done(input logic [31:0] data);
        in_sd_done     = 1'b1;
        in_sd_data_out = data;
        tick();
        in_sd_done     = 1'b0;
        in_sd_data_out = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sd_valid"}, out_sd_in_valid, 0);
        check({tag, "_sd_addr"},  out_sd_addr, 0);
        check({tag, "_sd_rw"},    out_sd_rw, 1);
        check({tag, "_sd_data"},  out_sd_data_in, 0);
        check({tag, "_sd_wmask"}, out_sd_wmask, 4'hF);
        check({tag, "_req_done"}, out_req_done, 0);
        check({tag, "_req_data"}, out_req_data_out, 0);
        check({tag, "_grant"},    out_grant, 0);
        check({tag, "_busy"},     out_busy, 0);
        check({tag, "_overrun"},  out_overrun, 0);
    endtask

    logic [GW-1:0] exp_first, exp_second;

    initial begin
        reset           = 1'b1;
        in_req_addr     = '0;
        in_req_rw       = '0;
        in_req_data_in  = '0;
        in_req_wmask    = '0;
        in_req_in_valid = '0;
        in_sd_data_out  = '0;
        in_sd_done      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_reset_state("rst");

        // single write on port 1: issue at +2, done at 6 -> req_done at 7
        set_req(1, 32'h100, 1'b1, 32'h00ABCDEF, 4'hF);
        tick();
        in_req_in_valid = '0;
        check("t1_c1_valid", out_sd_in_valid, 0);
        tick();
        check("t1_c2_valid", out_sd_in_valid, 1);
        check("t1_c2_addr",  out_sd_addr, 32'h100);
        check("t1_c2_data",  out_sd_data_in, 32'h00ABCDEF);
        check("t1_c2_rw",    out_sd_rw, 1);
        check("t1_c2_grant", out_grant, 1);
        check("t1_c2_busy",  out_busy, 1);
        tick();
        check("t1_c3_valid", out_sd_in_valid, 0);
        check("t1_c3_addr",  out_sd_addr, 32'h100);
        tick();
        tick();
        tick();
        check("t1_c6_done0", out_req_done, 0);
        sd_done(32'h1234);
        check("t1_c7_done",  out_req_done, 2'b10);
        check("t1_c7_busy",  out_busy, 0);
        tick();
        check("t1_c8_done",  out_req_done, 0);

        // simultaneous requests, pointer 0: port 0 read first, then port 1
        set_req(0, 32'h200, 1'b0, 32'h0, 4'hF);
        set_req(1, 32'h300, 1'b1, 32'h55, 4'h3);
        tick();
        in_req_in_valid = '0;
        tick();
        check("t2_first_valid", out_sd_in_valid, 1);
        check("t2_first_grant", out_grant, 0);
        check("t2_first_addr",  out_sd_addr, 32'h200);
        check("t2_first_rw",    out_sd_rw, 0);
        tick();
        sd_done(32'hDEADBEEF);
        check("t3_done",   out_req_done, 2'b01);
        check("t3_rdata",  out_req_data_out, 32'hDEADBEEF);
        check("t3_busy",   out_busy, 0);
        check("t2_gap_valid", out_sd_in_valid, 0);
        tick();
        check("t2_second_valid", out_sd_in_valid, 1);
        check("t2_second_grant", out_grant, 1);
        check("t2_second_addr",  out_sd_addr, 32'h300);
        check("t2_second_wmask", out_sd_wmask, 4'h3);
        check("t2_second_data",  out_sd_data_in, 32'h55);
        tick();
        sd_done(32'hCAFE);
        check("t2_second_done", out_req_done, 2'b10);
        tick();

        // single port-0 read moves pointer to 1 (round-robin build)
        set_req(0, 32'h800, 1'b0, 32'h0, 4'hF);
        tick();
        in_req_in_valid = '0;
        tick();
        check("t2b_grant", out_grant, 0);
        tick();
        sd_done(32'h11);
        check("t2b_done", out_req_done, 2'b01);
        tick();

        // simultaneous again: order flips unless port 0 has priority
`ifdef SDRAM_ARB_PORT0_PRIORITY_EN
        exp_first  = 2'd0;
        exp_second = 2'd1;
`else
        exp_first  = 2'd1;
        exp_second = 2'd0;
`endif
        set_req(0, 32'h900, 1'b0, 32'h0, 4'hF);
        set_req(1, 32'hA00, 1'b1, 32'h77, 4'hF);
        tick();
        in_req_in_valid = '0;
        tick();
        check("t2c_first_grant", out_grant, exp_first);
        check("t2c_first_addr",  out_sd_addr, (exp_first == 2'd0) ? 32'h900 : 32'hA00);
        tick();
        sd_done(32'h22);
        check("t2c_first_done", out_req_done, (exp_first == 2'd0) ? 2'b01 : 2'b10);
        tick();
        check("t2c_second_valid", out_sd_in_valid, 1);
        check("t2c_second_grant", out_grant, exp_second);
        tick();
        sd_done(32'h33);
        check("t2c_second_done", out_req_done, (exp_second == 2'd0) ? 2'b01 : 2'b10);
        tick();

        // overrun: second pulse on pending port 1 is dropped
        set_req(1, 32'h400, 1'b1, 32'h44, 4'hF);
        tick();
        check("t4_ovr_before", out_overrun, 0);
        set_req(1, 32'h500, 1'b1, 32'h66, 4'hF);
        tick();
        in_req_in_valid = '0;
        check("t4_valid",   out_sd_in_valid, 1);
        check("t4_addr",    out_sd_addr, 32'h400);
        check("t4_overrun", out_overrun, 1);
        tick();
        sd_done(32'h0);
        check("t4_done", out_req_done, 2'b10);
        tick();
        tick();
        check("t4_sticky", out_overrun, 1);
        check("t4_no_reissue", out_sd_in_valid, 0);

        // reset in WAIT abandons the transaction; late done ignored
        set_req(0, 32'h600, 1'b0, 32'h0, 4'hF);
        tick();
        in_req_in_valid = '0;
        tick();
        check("t5_busy", out_busy, 1);
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        in_sd_done = 1'b1;
        check_reset_state("t5_rst");
        tick();
        in_sd_done = 1'b0;
        check("t5_no_done",  out_req_done, 0);
        check("t5_idle",     out_busy, 0);
        tick();
        check("t5_no_done2", out_req_done, 0);
        check("t5_no_issue", out_sd_in_valid, 0);
        set_req(1, 32'h700, 1'b1, 32'h99, 4'h5);
        tick();
        in_req_in_valid = '0;
        tick();
        check("t5_new_valid", out_sd_in_valid, 1);
        check("t5_new_grant", out_grant, 1);
        check("t5_new_addr",  out_sd_addr, 32'h700);
        tick();
        sd_done(32'h0);
        check("t5_new_done", out_req_done, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
